// File: rtl/rx_pkg.sv
// Shared definitions for the RX I/Q word packer: tagged word layout and
// the capture state encoding.
package rx_pkg;

  localparam int WORD_W  = 32;
  localparam int FIELD_W = 13;

  localparam logic [1:0] I_SYNC = 2'b10;
  localparam logic [1:0] Q_SYNC = 2'b01;

  localparam int I_SYNC_LSB = 30;
  localparam int I_LSB      = 17;
  localparam int Q_SYNC_LSB = 14;
  localparam int Q_LSB      = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/rx_iq_format.sv
// Combinational packing of an I/Q pair (or the test ramp) into one tagged
// 32-bit word; narrower samples are MSB-aligned in their 13-bit fields.
module rx_iq_format
  import rx_pkg::*;
#(
  parameter int SAMPLE_W = 13
) (
  input  logic [SAMPLE_W-1:0] rx_i,
  input  logic [SAMPLE_W-1:0] rx_q,
  input  logic                test_mode,
  input  logic [SAMPLE_W-1:0] ramp,
  output logic [WORD_W-1:0]   word
);

  logic [SAMPLE_W-1:0] i_sel;
  logic [SAMPLE_W-1:0] q_sel;
  logic [FIELD_W-1:0]  i_field;
  logic [FIELD_W-1:0]  q_field;

  always_comb begin
    i_sel   = test_mode ? ramp  : rx_i;
    q_sel   = test_mode ? ~ramp : rx_q;
    i_field = FIELD_W'(i_sel) << (FIELD_W - SAMPLE_W);
    q_field = FIELD_W'(q_sel) << (FIELD_W - SAMPLE_W);

    word                       = '0;
    word[I_SYNC_LSB +: 2]      = I_SYNC;
    word[I_LSB +: FIELD_W]     = i_field;
    word[Q_SYNC_LSB +: 2]      = Q_SYNC;
    word[Q_LSB +: FIELD_W]     = q_field;
  end

endmodule

// File: rtl/rx_iq_word_packer.sv
// Per-channel I/Q word packer between the LVDS deserializer and the RX FIFO:
// single pending word, back-pressure with drop accounting, enable/drain FSM.
//
// state | meaning
// IDLE  | capture off, strobes ignored
// ARM   | first strobe (mid-pair) discarded, next one starts RUN
// RUN   | samples packed and pushed, dropped when FIFO is full
// DRAIN | no new samples, waiting for the pending word to leave
module rx_iq_word_packer
  import rx_pkg::*;
#(
  parameter int SAMPLE_W   = 13,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_test_mode,
  input  logic [SAMPLE_W-1:0]   i_rx_i,
  input  logic [SAMPLE_W-1:0]   i_rx_q,
  input  logic                  i_rx_valid,
  output logic                  o_fifo_push,
  output logic [WORD_W-1:0]     o_fifo_data,
  input  logic                  i_fifo_full,
  input  logic                  i_clr_stats,
  output logic [DROP_CNT_W-1:0] o_drop_count,
  output logic                  o_overflow,
  output logic                  o_active
);

  state_t              state;
  state_t              state_nxt;
  logic                pending;
  logic                armed;
  logic [SAMPLE_W-1:0] ramp;
  logic [WORD_W-1:0]   new_word;
  logic                take;
  logic                arm_consume;
  logic                enter_arm;
  logic                drop;

  rx_iq_format #(
    .SAMPLE_W (SAMPLE_W)
  ) u_format (
    .rx_i      (i_rx_i),
    .rx_q      (i_rx_q),
    .test_mode (i_test_mode),
    .ramp      (ramp),
    .word      (new_word)
  );

  assign o_fifo_push = pending & ~i_fifo_full;
  assign o_active    = (state != IDLE);
  assign drop        = take & pending & i_fifo_full;

  always_comb begin
    state_nxt   = state;
    take        = 1'b0;
    arm_consume = 1'b0;
    enter_arm   = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable) begin
          state_nxt = ARM;
          enter_arm = 1'b1;
        end
      end
      ARM: begin
        if (!i_enable) begin
          state_nxt = IDLE;
        end else if (i_rx_valid) begin
          if (!armed) begin
            arm_consume = 1'b1;
          end else begin
            take      = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!i_enable) begin
          state_nxt = DRAIN;
        end else if (i_rx_valid) begin
          take = 1'b1;
        end
      end
      DRAIN: begin
        // the pending word leaves this cycle or has already left
        if (!pending || !i_fifo_full) begin
          state_nxt = i_enable ? ARM : IDLE;
          enter_arm = i_enable;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pending     <= 1'b0;
      o_fifo_data <= '0;
    end else if (take && (!pending || !i_fifo_full)) begin
      pending     <= 1'b1;
      o_fifo_data <= new_word;
    end else if (o_fifo_push) begin
      pending     <= 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ramp  <= '0;
      armed <= 1'b0;
    end else if (enter_arm) begin
      ramp  <= '0;
      armed <= 1'b0;
    end else begin
      if (take) begin
        ramp <= ramp + SAMPLE_W'(1);
      end
      if (arm_consume) begin
        armed <= 1'b1;
      end
    end
  end

  // clear has priority over a coincident drop
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_drop_count <= '0;
      o_overflow   <= 1'b0;
    end else if (i_clr_stats) begin
      o_drop_count <= '0;
      o_overflow   <= 1'b0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (o_drop_count != '1) begin
        o_drop_count <= o_drop_count + DROP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_iq_word_packer.sv
// Self-checking bench for rx_iq_word_packer: randomized I/Q data, expected
// words and counts derived from the word format and accept rules.
module tb_rx_iq_word_packer;

  localparam int SW = 13;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          test_mode = 1'b0;
  logic [SW-1:0] rx_i = '0;
  logic [SW-1:0] rx_q = '0;
  logic          rx_valid = 1'b0;
  logic          fifo_push;
  logic [31:0]   fifo_data;
  logic          fifo_full = 1'b0;
  logic          clr_stats = 1'b0;
  logic [DW-1:0] drop_count;
  logic          overflow;
  logic          active;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int push_while_full = 0;
  logic [31:0] got_q[$];
  int          got_t[$];

  rx_iq_word_packer #(.SAMPLE_W(SW), .DROP_CNT_W(DW)) dut (
    .i_sys_clk    (clk),
    .i_reset_n    (rst_n),
    .i_enable     (enable),
    .i_test_mode  (test_mode),
    .i_rx_i       (rx_i),
    .i_rx_q       (rx_q),
    .i_rx_valid   (rx_valid),
    .o_fifo_push  (fifo_push),
    .o_fifo_data  (fifo_data),
    .i_fifo_full  (fifo_full),
    .i_clr_stats  (clr_stats),
    .o_drop_count (drop_count),
    .o_overflow   (overflow),
    .o_active     (active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (rst_n && fifo_push) begin
      got_q.push_back(fifo_data);
      got_t.push_back(cycle);
      if (fifo_full) push_while_full++;
    end
  end

  function automatic logic [31:0] exp_word(int i, int q);
    logic [31:0] iv, qv;
    iv = 32'(i & 'h1FFF);
    qv = 32'(q & 'h1FFF);
    return 32'h8000_4000 | (iv << 17) | (qv << 1);
  endfunction

  task automatic drive(input logic v, input int i, input int q);
    rx_valid = v;
    rx_i = SW'(i);
    rx_q = SW'(q);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0);
  endtask

  task automatic clear_stats();
    clr_stats = 1'b1;
    idle(1);
    clr_stats = 1'b0;
  endtask

  // enable and feed the mid-pair strobe that ARM discards
  task automatic start_session();
    enable = 1'b1;
    idle(1);
    drive(1'b1, $urandom_range(0, 8191), $urandom_range(0, 8191));
  endtask

  task automatic end_session();
    int n;
    enable = 1'b0;
    fifo_full = 1'b0;
    n = 0;
    while (active && n < 20) begin
      idle(1);
      n++;
    end
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL end_session_idle active=%b required 0", active);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    checks += 5;
    if (fifo_push !== 1'b0) begin errors++; $display("FAIL reset_push got %b req 0", fifo_push); end
    if (fifo_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h req 0", fifo_data); end
    if (drop_count !== '0) begin errors++; $display("FAIL reset_drop got %h req 0", drop_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b req 0", overflow); end
    if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b req 0", active); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_first_word();
    got_q.delete();
    start_session();
    drive(1'b1, 'h0123, 'h1FFF);
    checks += 3;
    if (fifo_push !== 1'b1) begin errors++; $display("FAIL first_push got %b req 1", fifo_push); end
    if (fifo_data !== 32'h8246_7FFE) begin errors++; $display("FAIL first_data got %h req 82467ffe", fifo_data); end
    if (active !== 1'b1) begin errors++; $display("FAIL first_active got %b req 1", active); end
    end_session();
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL first_count got %0d req 1", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    int i, q;
    got_q.delete();
    got_t.delete();
    clear_stats();
    start_session();
    for (int k = 0; k < 8; k++) begin
      i = $urandom_range(0, 8191);
      q = $urandom_range(0, 8191);
      exp_q.push_back(exp_word(i, q));
      drive(1'b1, i, q);
    end
    end_session();
    checks += 2;
    if (got_q.size() != 8) begin errors++; $display("FAIL b2b_count got %0d req 8", got_q.size()); end
    if (drop_count !== '0) begin errors++; $display("FAIL b2b_drops got %h req 0", drop_count); end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_word%0d got %h req %h", k, got_q[k], exp_q[k]); end
      if (k > 0) begin
        checks++;
        if (got_t[k] != got_t[k-1] + 1) begin
          errors++; $display("FAIL b2b_contig%0d got gap %0d req 1", k, got_t[k] - got_t[k-1]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] first;
    int i, q;
    got_q.delete();
    clear_stats();
    start_session();
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i = $urandom_range(0, 8191);
      q = $urandom_range(0, 8191);
      if (k == 0) first = exp_word(i, q);
      drive(1'b1, i, q);
    end
    checks += 5;
    if (fifo_push !== 1'b0) begin errors++; $display("FAIL ovf_push_full got %b req 0", fifo_push); end
    if (fifo_data !== first) begin errors++; $display("FAIL ovf_held got %h req %h", fifo_data, first); end
    if (drop_count !== DW'(4)) begin errors++; $display("FAIL ovf_drops got %0d req 4", drop_count); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b req 1", overflow); end
    if (got_q.size() != 0) begin errors++; $display("FAIL ovf_nopush got %0d req 0", got_q.size()); end
    fifo_full = 1'b0;
    idle(3);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== first) begin
      errors++; $display("FAIL ovf_release got %0d words req 1 of %h", got_q.size(), first);
    end
    end_session();
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL ovf_final_count got %0d req 1", got_q.size()); end
  endtask

  task automatic test_saturation();
    int drops;
    logic [31:0] first;
    got_q.delete();
    clear_stats();
    start_session();
    fifo_full = 1'b1;
    first = exp_word('h0AAA, 'h1555);
    drive(1'b1, 'h0AAA, 'h1555);
    drops = 0;
    for (int k = 0; k < 65534; k++) begin
      drive(1'b1, $urandom_range(0, 8191), $urandom_range(0, 8191));
      drops++;
    end
    checks++;
    if (drop_count !== DW'(drops)) begin errors++; $display("FAIL sat_pre got %h req %h", drop_count, DW'(drops)); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, $urandom_range(0, 8191), $urandom_range(0, 8191));
      drops++;
    end
    checks += 2;
    if (drop_count !== DW'((drops > 65535) ? 65535 : drops)) begin
      errors++; $display("FAIL sat_hold got %h req ffff", drop_count);
    end
    if (overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b req 1", overflow); end
    clr_stats = 1'b1;
    drive(1'b1, $urandom_range(0, 8191), $urandom_range(0, 8191));
    clr_stats = 1'b0;
    checks += 2;
    if (drop_count !== '0) begin errors++; $display("FAIL clr_wins_count got %h req 0", drop_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL clr_wins_ovf got %b req 0", overflow); end
    end_session();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== first) begin
      errors++; $display("FAIL sat_release got %0d words req 1 of %h", got_q.size(), first);
    end
  endtask

  task automatic test_drain();
    logic [31:0] w;
    int i, q, n;
    got_q.delete();
    start_session();
    fifo_full = 1'b1;
    i = $urandom_range(0, 8191);
    q = $urandom_range(0, 8191);
    w = exp_word(i, q);
    drive(1'b1, i, q);
    enable = 1'b0;
    drive(1'b1, $urandom_range(0, 8191), $urandom_range(0, 8191));
    idle(3);
    checks += 3;
    if (active !== 1'b1) begin errors++; $display("FAIL drain_active got %b req 1", active); end
    if (fifo_push !== 1'b0) begin errors++; $display("FAIL drain_push got %b req 0", fifo_push); end
    if (fifo_data !== w) begin errors++; $display("FAIL drain_held got %h req %h", fifo_data, w); end
    fifo_full = 1'b0;
    n = 0;
    while (active && n < 10) begin
      idle(1);
      n++;
    end
    idle(2);
    checks += 2;
    if (active !== 1'b0) begin errors++; $display("FAIL drain_idle got %b req 0", active); end
    if (got_q.size() != 1 || got_q[0] !== w) begin
      errors++; $display("FAIL drain_push_once got %0d words req 1 of %h", got_q.size(), w);
    end
  endtask

  task automatic test_pattern_and_reset();
    int base;
    got_q.delete();
    test_mode = 1'b1;
    start_session();
    for (int k = 0; k < 4; k++) drive(1'b1, $urandom_range(0, 8191), $urandom_range(0, 8191));
    idle(1);
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL ramp_count got %0d req 4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_word(k, 8191 - k)) begin
        errors++; $display("FAIL ramp_word%0d got %h req %h", k, got_q[k], exp_word(k, 8191 - k));
      end
    end
    fifo_full = 1'b1;
    drive(1'b1, 0, 0);
    drive(1'b1, 0, 0);
    fifo_full = 1'b0;
    base = got_q.size();
    #1;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (fifo_push !== 1'b0) begin errors++; $display("FAIL rst_mid_push got %b req 0", fifo_push); end
    if (fifo_data !== 32'h0) begin errors++; $display("FAIL rst_mid_data got %h req 0", fifo_data); end
    if (drop_count !== '0) begin errors++; $display("FAIL rst_mid_drop got %h req 0", drop_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf got %b req 0", overflow); end
    if (active !== 1'b0) begin errors++; $display("FAIL rst_mid_active got %b req 0", active); end
    enable = 1'b0;
    test_mode = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    checks++;
    if (got_q.size() != base) begin errors++; $display("FAIL rst_mid_nopush got %0d req %0d", got_q.size(), base); end
  endtask

  task automatic test_protocol();
    checks++;
    if (push_while_full != 0) begin errors++; $display("FAIL push_while_full got %0d req 0", push_while_full); end
  endtask

  initial begin
    #1;
    test_reset();
    test_first_word();
    test_back_to_back();
    test_overflow();
    test_saturation();
    test_drain();
    test_pattern_and_reset();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
